// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the icache and dcache onto the pipelined line memory.
// Tags reads with {client, seq} IDs and routes in-order responses back by ID MSB.
module mem_arbiter #(
  parameter int PA_WIDTH        = 32,
  parameter int LINE_WIDTH      = 128,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ic_req,
  input  logic [PA_WIDTH-1:0]   i_ic_addr,
  output logic                  o_ic_ready,
  output logic                  o_ic_resp_valid,
  output logic [LINE_WIDTH-1:0] o_ic_resp_data,
  input  logic                  i_ic_resp_ready,
  input  logic                  i_dc_req,
  input  logic                  i_dc_write,
  input  logic [PA_WIDTH-1:0]   i_dc_addr,
  input  logic [LINE_WIDTH-1:0] i_dc_data,
  output logic                  o_dc_ready,
  output logic                  o_dc_resp_valid,
  output logic [LINE_WIDTH-1:0] o_dc_resp_data,
  input  logic                  i_dc_resp_ready,
  output logic                  o_mem_enable,
  output logic                  o_mem_write,
  output logic [PA_WIDTH-1:0]   o_mem_addr,
  output logic [LINE_WIDTH-1:0] o_mem_data,
  output logic [ID_WIDTH-1:0]   o_mem_id,
  output logic                  o_mem_ack,
  input  logic                  i_mem_enable,
  input  logic [LINE_WIDTH-1:0] i_mem_data,
  input  logic [ID_WIDTH-1:0]   i_mem_id_response,
  input  logic                  i_mem_full
);

  localparam int TAG_W = ID_WIDTH - 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic                  ic_valid_q, ic_valid_d;
  logic [PA_WIDTH-1:0]   ic_addr_q, ic_addr_d;
  logic                  dc_valid_q, dc_valid_d;
  logic                  dc_write_q, dc_write_d;
  logic [PA_WIDTH-1:0]   dc_addr_q, dc_addr_d;
  logic [LINE_WIDTH-1:0] dc_data_q, dc_data_d;
  logic [TAG_W-1:0]      ic_seq_q, ic_seq_d;
  logic [TAG_W-1:0]      dc_seq_q, dc_seq_d;
  logic [CNT_W-1:0]      ic_out_q, ic_out_d;
  logic [CNT_W-1:0]      dc_out_q, dc_out_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_write_q, mem_write_d;
  logic [PA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [ID_WIDTH-1:0]   mem_id_q, mem_id_d;

  logic ic_elig, dc_elig, issue, grant_dc, ic_issue, dc_issue;
  logic resp_sel, ic_ack, dc_ack, ic_inc, dc_inc, ic_dec, dc_dec;

  // Writes bypass the outstanding limit since they never produce a response.
  always_comb begin
    ic_elig  = ic_valid_q && (ic_out_q < MAX_CNT);
    dc_elig  = dc_valid_q && (dc_write_q || (dc_out_q < MAX_CNT));
    issue    = !i_mem_full && (ic_elig || dc_elig);
    if (ic_elig && dc_elig) begin
      grant_dc = !last_grant_q;
    end else begin
      grant_dc = dc_elig;
    end
    ic_issue = issue && !grant_dc;
    dc_issue = issue && grant_dc;
  end

  assign o_ic_ready = !ic_valid_q || ic_issue;
  assign o_dc_ready = !dc_valid_q || dc_issue;

  assign resp_sel        = i_mem_id_response[ID_WIDTH-1];
  assign o_ic_resp_valid = i_mem_enable && !resp_sel;
  assign o_dc_resp_valid = i_mem_enable && resp_sel;
  assign o_ic_resp_data  = i_mem_data;
  assign o_dc_resp_data  = i_mem_data;
  assign o_mem_ack       = i_mem_enable && (resp_sel ? i_dc_resp_ready : i_ic_resp_ready);
  assign ic_ack          = o_mem_ack && !resp_sel;
  assign dc_ack          = o_mem_ack && resp_sel;

  // A new request may land in the same cycle its predecessor is issued.
  always_comb begin
    ic_valid_d = ic_valid_q;
    ic_addr_d  = ic_addr_q;
    dc_valid_d = dc_valid_q;
    dc_write_d = dc_write_q;
    dc_addr_d  = dc_addr_q;
    dc_data_d  = dc_data_q;
    if (ic_issue) ic_valid_d = 1'b0;
    if (dc_issue) dc_valid_d = 1'b0;
    if (i_ic_req && o_ic_ready) begin
      ic_valid_d = 1'b1;
      ic_addr_d  = i_ic_addr;
    end
    if (i_dc_req && o_dc_ready) begin
      dc_valid_d = 1'b1;
      dc_write_d = i_dc_write;
      dc_addr_d  = i_dc_addr;
      dc_data_d  = i_dc_data;
    end
  end

  always_comb begin
    ic_inc   = ic_issue;
    dc_inc   = dc_issue && !dc_write_q;
    ic_dec   = ic_ack && (ic_out_q != '0);
    dc_dec   = dc_ack && (dc_out_q != '0);
    ic_seq_d = ic_seq_q + TAG_W'(ic_inc);
    dc_seq_d = dc_seq_q + TAG_W'(dc_inc);
    ic_out_d = ic_out_q;
    dc_out_d = dc_out_q;
    if (ic_inc && !ic_dec) ic_out_d = ic_out_q + 1'b1;
    if (!ic_inc && ic_dec) ic_out_d = ic_out_q - 1'b1;
    if (dc_inc && !dc_dec) dc_out_d = dc_out_q + 1'b1;
    if (!dc_inc && dc_dec) dc_out_d = dc_out_q - 1'b1;
    last_grant_d = issue ? grant_dc : last_grant_q;
  end

  // The request register freezes while memory is full so a held request is resampled.
  always_comb begin
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_id_d     = mem_id_q;
    if (!i_mem_full) begin
      mem_enable_d = issue;
      if (issue) begin
        mem_write_d = grant_dc ? dc_write_q : 1'b0;
        mem_addr_d  = grant_dc ? dc_addr_q : ic_addr_q;
        mem_data_d  = grant_dc ? dc_data_q : '0;
        mem_id_d    = grant_dc ? {1'b1, dc_seq_q} : {1'b0, ic_seq_q};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic_valid_q   <= 1'b0;
      ic_addr_q    <= '0;
      dc_valid_q   <= 1'b0;
      dc_write_q   <= 1'b0;
      dc_addr_q    <= '0;
      dc_data_q    <= '0;
      ic_seq_q     <= '0;
      dc_seq_q     <= '0;
      ic_out_q     <= '0;
      dc_out_q     <= '0;
      last_grant_q <= 1'b1;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_id_q     <= '0;
    end else begin
      ic_valid_q   <= ic_valid_d;
      ic_addr_q    <= ic_addr_d;
      dc_valid_q   <= dc_valid_d;
      dc_write_q   <= dc_write_d;
      dc_addr_q    <= dc_addr_d;
      dc_data_q    <= dc_data_d;
      ic_seq_q     <= ic_seq_d;
      dc_seq_q     <= dc_seq_d;
      ic_out_q     <= ic_out_d;
      dc_out_q     <= dc_out_d;
      last_grant_q <= last_grant_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_id_q     <= mem_id_d;
    end
  end

  assign o_mem_enable = mem_enable_q;
  assign o_mem_write  = mem_write_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_data   = mem_data_q;
  assign o_mem_id     = mem_id_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random cache traffic against a pipelined in-order memory model,
// per-client expected request/response queues popped by an independent monitor.
module tb_mem_arbiter;
  localparam int PA   = 32;
  localparam int LW   = 128;
  localparam int IDW  = 4;
  localparam int TAGW = IDW - 1;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst;
  logic i_ic_req, o_ic_ready, o_ic_resp_valid, i_ic_resp_ready;
  logic [PA-1:0] i_ic_addr;
  logic [LW-1:0] o_ic_resp_data;
  logic i_dc_req, i_dc_write, o_dc_ready, o_dc_resp_valid, i_dc_resp_ready;
  logic [PA-1:0] i_dc_addr;
  logic [LW-1:0] i_dc_data, o_dc_resp_data;
  logic o_mem_enable, o_mem_write, o_mem_ack, i_mem_enable, i_mem_full;
  logic [PA-1:0] o_mem_addr;
  logic [LW-1:0] o_mem_data, i_mem_data;
  logic [IDW-1:0] o_mem_id, i_mem_id_response;

  always #5 clk = ~clk;

  mem_arbiter #(.PA_WIDTH(PA), .LINE_WIDTH(LW), .ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .i_ic_req(i_ic_req), .i_ic_addr(i_ic_addr), .o_ic_ready(o_ic_ready),
    .o_ic_resp_valid(o_ic_resp_valid), .o_ic_resp_data(o_ic_resp_data), .i_ic_resp_ready(i_ic_resp_ready),
    .i_dc_req(i_dc_req), .i_dc_write(i_dc_write), .i_dc_addr(i_dc_addr), .i_dc_data(i_dc_data),
    .o_dc_ready(o_dc_ready), .o_dc_resp_valid(o_dc_resp_valid), .o_dc_resp_data(o_dc_resp_data),
    .i_dc_resp_ready(i_dc_resp_ready),
    .o_mem_enable(o_mem_enable), .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .o_mem_id(o_mem_id), .o_mem_ack(o_mem_ack),
    .i_mem_enable(i_mem_enable), .i_mem_data(i_mem_data), .i_mem_id_response(i_mem_id_response),
    .i_mem_full(i_mem_full)
  );

  typedef struct {
    logic          write;
    logic [PA-1:0] addr;
    logic [LW-1:0] data;
    logic [IDW-1:0] id;
  } req_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [LW-1:0]  data;
    int             ready_at;
  } mresp_t;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  req_t          ic_exp_q[$];
  req_t          dc_exp_q[$];
  logic [LW-1:0] ic_resp_exp_q[$];
  logic [LW-1:0] dc_resp_exp_q[$];
  mresp_t        mem_resp_q[$];
  logic [4:0]    issue_log[$];
  logic [LW-1:0] ref_mem[logic [PA-1:0]];
  logic [LW-1:0] mem_model[logic [PA-1:0]];
  int            ic_reads, dc_reads;
  int            inflight[2];
  logic [LW-1:0] last_dc_resp;

  logic ic_hs = 1'b0;
  logic dc_hs = 1'b0;
  bit   ic_en, dc_en, mem_hold;
  int   req_pct, wr_pct, full_pct, rdy_pct, lat_max;
  bit   pend_ic, pend_dc, pend_dc_write;
  logic [PA-1:0] pend_ic_addr, pend_dc_addr;
  logic [LW-1:0] pend_dc_data;

  function automatic logic [LW-1:0] init_line(logic [PA-1:0] a);
    return {4{a ^ 32'hA5A5_0000}};
  endfunction

  function automatic logic [LW-1:0] ref_read(logic [PA-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic logic [LW-1:0] mem_read(logic [PA-1:0] a);
    return mem_model.exists(a) ? mem_model[a] : init_line(a);
  endfunction

  task automatic check_output(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One clock of stimulus plus the memory model; handshakes are resolved at #1 after the falling edge.
  task automatic apply_stimulus();
    @(negedge clk);
    cycle++;
    if (ic_hs) i_ic_req = 1'b0;
    if (dc_hs) i_dc_req = 1'b0;
    if (!i_ic_req) begin
      if (pend_ic) begin
        i_ic_req = 1'b1; i_ic_addr = pend_ic_addr; pend_ic = 1'b0;
      end else if (ic_en && $urandom_range(99) < req_pct) begin
        i_ic_req = 1'b1; i_ic_addr = 32'h1000 + ($urandom_range(15) << 4);
      end
    end
    if (!i_dc_req) begin
      if (pend_dc) begin
        i_dc_req = 1'b1; i_dc_write = pend_dc_write; i_dc_addr = pend_dc_addr;
        i_dc_data = pend_dc_data; pend_dc = 1'b0;
      end else if (dc_en && $urandom_range(99) < req_pct) begin
        i_dc_req   = 1'b1;
        i_dc_write = ($urandom_range(99) < wr_pct);
        i_dc_addr  = 32'h2000 + ($urandom_range(3) << 4);
        i_dc_data  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    i_mem_full      = ($urandom_range(99) < full_pct);
    i_ic_resp_ready = ($urandom_range(99) < rdy_pct);
    i_dc_resp_ready = ($urandom_range(99) < rdy_pct);
    if (!mem_hold && mem_resp_q.size() > 0 && mem_resp_q[0].ready_at <= cycle) begin
      i_mem_enable = 1'b1; i_mem_id_response = mem_resp_q[0].id; i_mem_data = mem_resp_q[0].data;
    end else begin
      i_mem_enable = 1'b0; i_mem_id_response = IDW'($urandom); i_mem_data = {$urandom, $urandom, $urandom, $urandom};
    end
    #1;
    ic_hs = i_ic_req && o_ic_ready;
    dc_hs = i_dc_req && o_dc_ready;
    if (ic_hs) begin
      ic_exp_q.push_back('{1'b0, i_ic_addr, '0, {1'b0, TAGW'(ic_reads)}});
      ic_resp_exp_q.push_back(ref_read(i_ic_addr));
      ic_reads++;
    end
    if (dc_hs) begin
      dc_exp_q.push_back('{i_dc_write, i_dc_addr, i_dc_data, {1'b1, TAGW'(dc_reads)}});
      if (i_dc_write) begin
        ref_mem[i_dc_addr] = i_dc_data;
      end else begin
        dc_resp_exp_q.push_back(ref_read(i_dc_addr));
        dc_reads++;
      end
    end
    if (o_mem_enable && !i_mem_full) begin
      if (o_mem_write) mem_model[o_mem_addr] = o_mem_data;
      else mem_resp_q.push_back('{o_mem_id, mem_read(o_mem_addr), cycle + int'($urandom_range(lat_max, 1))});
    end
    if (o_mem_ack && mem_resp_q.size() > 0) void'(mem_resp_q.pop_front());
  endtask

  // Monitor: compares whatever the DUT presents this cycle against the expected queues.
  logic [PA+LW+IDW+1:0] prev_snap;
  bit prev_full = 1'b0;
  bit prev_valid = 1'b0;
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      check_output("resp_route", {o_mem_ack, o_ic_resp_valid, o_dc_resp_valid},
                   {i_mem_enable && (i_mem_id_response[IDW-1] ? i_dc_resp_ready : i_ic_resp_ready),
                    i_mem_enable && !i_mem_id_response[IDW-1], i_mem_enable && i_mem_id_response[IDW-1]});
      if (i_mem_enable)
        check_output("resp_data", i_mem_id_response[IDW-1] ? o_dc_resp_data : o_ic_resp_data, i_mem_data);
      if (prev_valid && prev_full)
        check_output("full_hold", {o_mem_enable, o_mem_write, o_mem_addr, o_mem_data, o_mem_id}, prev_snap);
      if (o_mem_enable && !i_mem_full) begin
        req_t e;
        int c;
        c = o_mem_id[IDW-1] ? 1 : 0;
        if ((c == 1 ? dc_exp_q.size() : ic_exp_q.size()) == 0) begin
          check_output("unexpected_issue", {o_mem_write, o_mem_id}, '1);
        end else begin
          e = (c == 1) ? dc_exp_q.pop_front() : ic_exp_q.pop_front();
          check_output("issue_req", {o_mem_write, o_mem_addr, o_mem_id}, {e.write, e.addr, e.id});
          if (e.write) check_output("issue_wdata", o_mem_data, e.data);
          else begin
            check_output("outstanding_limit", inflight[c] < MAXO, 1);
            inflight[c]++;
          end
        end
        issue_log.push_back({o_mem_write, o_mem_id});
      end
      if (o_ic_resp_valid && i_ic_resp_ready) begin
        inflight[0]--;
        if (ic_resp_exp_q.size() == 0) check_output("unexpected_ic_resp", 0, 1);
        else check_output("ic_resp_data", o_ic_resp_data, ic_resp_exp_q.pop_front());
      end
      if (o_dc_resp_valid && i_dc_resp_ready) begin
        inflight[1]--;
        last_dc_resp = o_dc_resp_data;
        if (dc_resp_exp_q.size() == 0) check_output("unexpected_dc_resp", 0, 1);
        else check_output("dc_resp_data", o_dc_resp_data, dc_resp_exp_q.pop_front());
      end
      prev_snap  = {o_mem_enable, o_mem_write, o_mem_addr, o_mem_data, o_mem_id};
      prev_full  = i_mem_full;
      prev_valid = 1'b1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    i_ic_req = 1'b0; i_dc_req = 1'b0; i_mem_enable = 1'b0; i_mem_full = 1'b0;
    ic_hs = 1'b0; dc_hs = 1'b0; pend_ic = 1'b0; pend_dc = 1'b0;
    #1;
    check_output("reset_ready", {o_ic_ready, o_dc_ready}, 2'b11);
    check_output("reset_mem_out", {o_mem_enable, o_mem_write, o_mem_addr, o_mem_data, o_mem_id}, '0);
    ic_exp_q.delete(); dc_exp_q.delete(); ic_resp_exp_q.delete(); dc_resp_exp_q.delete();
    mem_resp_q.delete(); issue_log.delete();
    ref_mem = mem_model;
    ic_reads = 0; dc_reads = 0; inflight[0] = 0; inflight[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    bit done;
    ic_en = 1'b0; dc_en = 1'b0; full_pct = 0; rdy_pct = 100; mem_hold = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      apply_stimulus();
      done = (!i_ic_req || ic_hs) && (!i_dc_req || dc_hs) && !pend_ic && !pend_dc &&
             ic_exp_q.size() == 0 && dc_exp_q.size() == 0 && mem_resp_q.size() == 0 &&
             ic_resp_exp_q.size() == 0 && dc_resp_exp_q.size() == 0;
    end
    repeat (3) apply_stimulus();
    check_output("drain_complete", done, 1);
  endtask

  initial begin
    logic [3:0] ic_ids[$];
    bit got;
    rst = 1'b1;
    i_ic_req = 0; i_ic_addr = '0; i_dc_req = 0; i_dc_write = 0; i_dc_addr = '0; i_dc_data = '0;
    i_ic_resp_ready = 0; i_dc_resp_ready = 0; i_mem_enable = 0; i_mem_data = '0;
    i_mem_id_response = '0; i_mem_full = 0;
    ic_en = 0; dc_en = 0; mem_hold = 0; req_pct = 100; wr_pct = 0; full_pct = 0; rdy_pct = 100; lat_max = 1;
    pend_ic = 0; pend_dc = 0; pend_dc_write = 0; pend_ic_addr = '0; pend_dc_addr = '0; pend_dc_data = '0;
    do_reset();

    // Single icache read: issue latency, ID, outstanding bookkeeping
    pend_ic = 1'b1; pend_ic_addr = 32'h100;
    apply_stimulus();
    check_output("single_handshake", ic_hs, 1);
    apply_stimulus();
    check_output("single_not_early", o_mem_enable, 0);
    apply_stimulus();
    check_output("single_issue", {o_mem_enable, o_mem_write, o_mem_id, o_mem_addr}, {1'b1, 1'b0, 4'h0, 32'h100});
    check_output("single_outstanding", dut.ic_out_q, 1);
    repeat (5) apply_stimulus();
    check_output("single_outstanding_back", dut.ic_out_q, 0);

    // Both clients reading every cycle: strict alternation starting with icache
    do_reset();
    ic_en = 1; dc_en = 1; req_pct = 100; wr_pct = 0;
    repeat (8) apply_stimulus();
    check_output("rr_order", {issue_log[0], issue_log[1], issue_log[2], issue_log[3]},
                 {5'h00, 5'h08, 5'h01, 5'h09});
    drain();

    // icache saturates MAX_OUTSTANDING while dcache writes still get through
    do_reset();
    ic_en = 1; dc_en = 0; req_pct = 100; mem_hold = 1;
    repeat (10) apply_stimulus();
    check_output("limit_ready_low", o_ic_ready, 0);
    check_output("limit_issue_count", issue_log.size(), 4);
    pend_dc = 1; pend_dc_write = 1; pend_dc_addr = 32'h2300; pend_dc_data = 128'hBEEF;
    repeat (4) apply_stimulus();
    check_output("limit_write_passes", issue_log[issue_log.size()-1], 5'h18);
    mem_hold = 0;
    repeat (20) apply_stimulus();
    foreach (issue_log[i]) if (!issue_log[i][3]) ic_ids.push_back(issue_log[i][3:0]);
    check_output("limit_fifth_tag", ic_ids.size() >= 5 ? ic_ids[4] : 4'hF, 4'h4);
    drain();

    // dcache write then read of the same line
    pend_dc = 1; pend_dc_write = 1; pend_dc_addr = 32'h200; pend_dc_data = 128'h1234;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin apply_stimulus(); got = dc_hs; end
    pend_dc = 1; pend_dc_write = 0; pend_dc_addr = 32'h200;
    drain();
    check_output("raw_read_data", last_dc_resp, 128'h1234);

    // Random traffic with stalls, slow consumers and variable latency
    ic_en = 1; dc_en = 1; req_pct = 60; wr_pct = 40; full_pct = 20; rdy_pct = 70; lat_max = 4;
    repeat (2000) apply_stimulus();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
